// File: rtl/packer_scheduler_pkg.sv
// Shared definitions for the packer scheduler: FSM encodings and the
// rotating first-set-bit search used by the round-robin arbiter.
package packer_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } sched_state_e;

  // Widest request vector the search helper can scan.
  localparam int unsigned RR_MAX_N = 64;

  // Index of the first set bit of req[n-1:0], scanning ptr+1 upward and
  // wrapping back around to ptr itself. Returns ptr when nothing is set;
  // callers qualify the result with |req.
  function automatic int unsigned rr_first(input logic [RR_MAX_N-1:0] req,
                                           input int unsigned         ptr,
                                           input int unsigned         n);
    int unsigned idx;
    logic        found;
    rr_first = ptr;
    found    = 1'b0;
    for (int unsigned off = 1; off <= RR_MAX_N; off++) begin
      if (off <= n) begin
        idx = ptr + off;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[5:0]]) begin
          rr_first = idx;
          found    = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/packer_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the requester just after ptr has the
// highest priority, ptr itself the lowest. Shared by other resource
// controllers, so it carries no state of its own.
module rr_arbiter
  import packer_scheduler_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [RR_MAX_N-1:0] req_ext;
  int unsigned         pick;

  // Widen the request vector for the helper and decode its pick to one-hot.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_first(req_ext, 32'(ptr), 32'(N));
    valid          = |req;
    idx            = W'(pick);
    gnt            = '0;
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/packer_scheduler.sv
// Serializes forced-mode packer ports one at a time: latches per-port
// requests, grants round-robin with a one-cycle port_ready strobe, waits for
// the packer to finish, and aborts via a watchdog if it never does.
module packer_scheduler
  import packer_scheduler_pkg::*;
#(
  parameter  int NPORTS         = 8,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int PTR_W          = $clog2(NPORTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req,
  input  logic              err_clr,
  input  logic              byte_ready,
  input  logic              data_packed,
  output logic [NPORTS-1:0] grant,
  output logic [NPORTS-1:0] done,
  output logic              busy,
  output logic [PTR_W-1:0]  cur_port,
  output logic [NPORTS-1:0] ovf_err,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value on the last cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_e      state_q, state_d;
  logic [NPORTS-1:0] pending_q, pending_d;
  logic [NPORTS-1:0] ovf_q, ovf_d;
  logic              timeout_q, timeout_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [NPORTS-1:0] done_q, done_d;
  logic              busy_q, busy_d;
  logic [PTR_W-1:0]  cur_q, cur_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NPORTS-1:0] arb_gnt;
  logic [PTR_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [NPORTS-1:0] gnt_now;
  logic              timeout_set;

  rr_arbiter #(.N(NPORTS), .W(PTR_W)) u_arb (
    .req   (pending_q),
    .ptr   (rr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Next state, grant/done strobes and the watchdog counter.
  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    done_d      = '0;
    busy_d      = busy_q;
    cur_d       = cur_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    gnt_now     = '0;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (arb_valid) begin
          gnt_now = arb_gnt;
          grant_d = arb_gnt;
          cur_d   = arb_idx;
          rr_d    = arb_idx;
          busy_d  = 1'b1;
          state_d = ST_WAIT_START;
        end
      end
      ST_WAIT_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          timeout_set = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else if (byte_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion landing on the final watchdog cycle still counts.
        if (data_packed) begin
          done_d[cur_q] = 1'b1;
          busy_d        = 1'b0;
          cnt_d         = '0;
          state_d       = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_set = 1'b1;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request bookkeeping: a new request on the granted port re-arms it, and
  // sticky errors are set with priority over a same-cycle clear.
  always_comb begin
    pending_d = (pending_q & ~gnt_now) | req;
    ovf_d     = (err_clr ? '0 : ovf_q) | (req & pending_q & ~gnt_now);
    timeout_d = (err_clr ? 1'b0 : timeout_q) | timeout_set;
  end

  // State and output registers; reset drops all queued work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ovf_q     <= '0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      cur_q     <= '0;
      rr_q      <= PTR_W'(NPORTS - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cur_q     <= cur_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign cur_port    = cur_q;
  assign ovf_err     = ovf_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_packer_scheduler.sv
// Scoreboard bench for packer_scheduler with a behavioural forced-mode packer
// (every port 8 bytes). Stimulus pushes expected grant/done/timeout events;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_packer_scheduler;

  localparam int N = 8;
  localparam int T = 64;

  localparam logic [1:0] EV_GRANT = 2'd0;
  localparam logic [1:0] EV_DONE  = 2'd1;
  localparam logic [1:0] EV_TO    = 2'd2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         err_clr;
  logic         byte_ready;
  logic         data_packed;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic [2:0]   cur_port;
  logic [N-1:0] ovf_err;
  logic         timeout_err;

  packer_scheduler #(.NPORTS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .err_clr     (err_clr),
    .byte_ready  (byte_ready),
    .data_packed (data_packed),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .cur_port    (cur_port),
    .ovf_err     (ovf_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;
    int         port;
  } ev_t;

  ev_t  exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic pk_block = 1'b0;
  logic prev_to  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic logic [31:0] ev_code(input logic [1:0] k, input logic [7:0] v);
    return {22'd0, k, v};
  endfunction

  task automatic push(input logic [1:0] k, input int p);
    ev_t e;
    e.kind = k;
    e.port = p;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [1:0] k, input logic [7:0] v);
    ev_t        e;
    logic [7:0] ev;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected_event: got kind %0d vec %0h expected none", k, v);
    end else begin
      e  = exp_q.pop_front();
      ev = (e.kind == EV_TO) ? 8'h00 : (8'h01 << e.port);
      chk("event", ev_code(k, v), ev_code(e.kind, ev));
    end
  endtask

  // Monitor: every grant, done and timeout rise must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (grant != '0) pop_cmp(EV_GRANT, grant);
      if (done != '0) pop_cmp(EV_DONE, done);
      if (timeout_err && !prev_to) pop_cmp(EV_TO, 8'h00);
    end
    prev_to <= timeout_err;
  end

  // Packer model: after port_ready, stream 8 byte_ready pulses then
  // data_packed; when blocked, emit one byte and stall forever.
  int   pk_nb;
  logic pk_ab;
  initial begin
    byte_ready  = 1'b0;
    data_packed = 1'b0;
    forever begin
      @(negedge clk);
      if (grant != '0 && !reset) begin
        pk_nb = pk_block ? 1 : 8;
        pk_ab = 1'b0;
        for (int b = 0; b < pk_nb && !pk_ab; b++) begin
          @(posedge clk); #1;
          if (reset) pk_ab = 1'b1;
          else byte_ready = 1'b1;
          @(posedge clk); #1;
          byte_ready = 1'b0;
          if (reset) pk_ab = 1'b1;
        end
        if (!pk_block && !pk_ab) begin
          @(posedge clk); #1;
          data_packed = 1'b1;
          @(posedge clk); #1;
          data_packed = 1'b0;
        end
      end
    end
  end

  task automatic pulse_req(input logic [N-1:0] v);
    @(posedge clk); #1;
    req = v;
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic wait_grant(input string nm, input logic [N-1:0] v);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (grant == v) ok = 1'b1;
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    chk(nm, {busy, 31'(exp_q.size())}, 32'd0);
  endtask

  initial begin
    logic ok;
    reset   = 1'b1;
    req     = '0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {grant, done, busy, cur_port, ovf_err, timeout_err},
        32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // All ports at once: strict 0..7 order, one transfer at a time.
    for (int p = 0; p < N; p++) begin
      push(EV_GRANT, p);
      push(EV_DONE, p);
    end
    pulse_req(8'hFF);
    wait_drain("all_ports_drain");
    chk("all_ports_no_ovf", 32'(ovf_err), 32'd0);

    // Single request: grant registered two edges after the request edge.
    push(EV_GRANT, 2);
    push(EV_DONE, 2);
    pulse_req(8'h04);
    @(negedge clk);
    chk("lat_grant_early", 32'(grant), 32'h00);
    @(negedge clk);
    chk("lat_grant", 32'(grant), 32'h04);
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_cur_port", 32'(cur_port), 32'd2);
    @(negedge clk);
    chk("lat_grant_pulse", 32'(grant), 32'h00);
    wait_drain("single_drain");

    // Repeat on port 1 while it waits behind port 3: overflow, one grant.
    push(EV_GRANT, 3);
    push(EV_DONE, 3);
    push(EV_GRANT, 1);
    push(EV_DONE, 1);
    @(posedge clk); #1; req = 8'h08;
    @(posedge clk); #1; req = 8'h02;
    @(posedge clk); #1; req = 8'h02;
    @(posedge clk); #1; req = 8'h00;
    wait_drain("ovf_drain");
    chk("ovf_set", 32'(ovf_err), 32'h02);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 32'(ovf_err), 32'h00);

    // Stalled packer: watchdog fires exactly TIMEOUT_CYCLES after grant.
    pk_block = 1'b1;
    push(EV_GRANT, 4);
    push(EV_TO, 0);
    pulse_req(8'h10);
    wait_grant("to_grant_seen", 8'h10);
    repeat (T - 1) @(negedge clk);
    chk("to_not_yet", {busy, timeout_err}, 32'b10);
    @(negedge clk);
    chk("to_fired", {busy, timeout_err, done}, {22'd0, 1'b0, 1'b1, 8'h00});
    pk_block = 1'b0;
    wait_drain("to_drain");
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    chk("to_clear", 32'(timeout_err), 32'd0);

    // Fairness: port 5 is served before port 0's re-request.
    push(EV_GRANT, 0);
    push(EV_DONE, 0);
    push(EV_GRANT, 5);
    push(EV_DONE, 5);
    push(EV_GRANT, 0);
    push(EV_DONE, 0);
    pulse_req(8'h01);
    wait_grant("rr_grant0_seen", 8'h01);
    pulse_req(8'h20);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (done[0]) ok = 1'b1;
    end
    chk("rr_done0_seen", 32'(ok), 32'd1);
    req = 8'h01;
    @(posedge clk); #1;
    req = 8'h00;
    wait_drain("rr_drain");

    // Reset in WAIT_DONE with port 2 queued: everything dropped.
    push(EV_GRANT, 6);
    pulse_req(8'h40);
    wait_grant("rst_grant_seen", 8'h40);
    pulse_req(8'h04);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
    end
    chk("rst_byte_seen", 32'(ok), 32'd1);
    @(posedge clk); #2;
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_outputs", {grant, done, busy, cur_port, ovf_err, timeout_err},
        32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_pending_dropped", {busy, 31'(exp_q.size())}, 32'd0);
    push(EV_GRANT, 6);
    push(EV_DONE, 6);
    pulse_req(8'h40);
    wait_drain("rst_fresh_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
